fir_mse_meter: RTL

Streaming error-metric block that sits downstream of the FIR filters in the approximate-adder evaluation flow. It consumes, per accepted sample, the output of an exact reference FIR and of an approximate FIR (`y_ref`, `y_apx`). Over a window of 2^LOG2_N samples it accumulates the squared difference and reports the mean squared error (MSE). It is the measurement end of the filter datapath: the FIR produces samples, this block reads and scores them.

---
 rtl/fir_metric_pkg.sv | 10 +
 rtl/sq_err_stage.sv | 57 +++++
 rtl/fir_mse_meter.sv | 113 +++++++++++
 3 files changed

// File: rtl/fir_metric_pkg.sv
// Shared types and constants for the FIR error-metric blocks.
package fir_metric_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} mse_state_e;

  localparam int DEF_DATA_W   = 16;
  localparam int DRAIN_CYCLES = 2;
  localparam int PIPE_STAGES  = 2;

endpackage

// File: rtl/sq_err_stage.sv
// S1/S2 of the MSE pipeline: signed difference, then its square.
// With FIR_MSE_PEAK_EN defined it also exposes |diff| and the S1 valid.
module sq_err_stage
  import fir_metric_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                      clk,
  input  logic                      rstN,
  input  logic                      clr,
  input  logic                      in_vld,
  input  logic [DATA_W-1:0]         y_ref,
  input  logic [DATA_W-1:0]         y_apx,
`ifdef FIR_MSE_PEAK_EN
  output logic                      s1_vld,
  output logic [DATA_W:0]           abs_diff,
`endif
  output logic                      s2_vld,
  output logic [2*(DATA_W+1)-1:0]   sq
);

  localparam int STAGES = PIPE_STAGES;
  localparam int SQ_W   = 2 * (DATA_W + 1);

  logic [STAGES:0]        vld_pipe;
  logic signed [DATA_W:0] diff;
  logic signed [DATA_W:0] diff_nxt;
  logic signed [SQ_W-1:0] dx;
  logic signed [SQ_W-1:0] prod;

  assign vld_pipe[0] = in_vld;
  assign diff_nxt    = {y_ref[DATA_W-1], y_ref} - {y_apx[DATA_W-1], y_apx};

  // Widen before multiplying so the low SQ_W bits hold the exact square.
  assign dx   = {{(DATA_W+1){diff[DATA_W]}}, diff};
  assign prod = dx * dx;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      vld_pipe[STAGES:1] <= '0;
      diff               <= '0;
      sq                 <= '0;
    end else begin
      vld_pipe[STAGES:1] <= clr ? '0 : vld_pipe[STAGES-1:0];
      if (vld_pipe[0]) diff <= diff_nxt;
      if (vld_pipe[1]) sq   <= prod;
    end
  end

  assign s2_vld = vld_pipe[2];

`ifdef FIR_MSE_PEAK_EN
  assign s1_vld   = vld_pipe[1];
  assign abs_diff = diff[DATA_W] ? unsigned'(-diff) : unsigned'(diff);
`endif

endmodule

// File: rtl/fir_mse_meter.sv
// Windowed mean-squared-error meter for exact vs approximate FIR outputs.
// Define FIR_MSE_PEAK_EN to also track the peak |y_ref - y_apx| per window.
module fir_mse_meter
  import fir_metric_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int LOG2_N = 10,
  parameter int ACC_W  = 48
) (
  input  logic                     clk,
  input  logic                     rstN,
  input  logic                     start,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        y_ref,
  input  logic [DATA_W-1:0]        y_apx,
  output logic                     busy,
  output logic                     done,
  output logic [ACC_W-LOG2_N-1:0]  mse,
  output logic [LOG2_N:0]          sample_cnt,
  output logic [DATA_W:0]          err_peak
);

  localparam int SQ_W = 2 * (DATA_W + 1);
  localparam logic [LOG2_N:0] LAST_IDX = (LOG2_N+1)'((1 << LOG2_N) - 1);

  mse_state_e        state, state_nxt;
  logic              drain_cnt;
  logic              accept, clr;
  logic              s2_vld;
  logic [SQ_W-1:0]   sq;
  logic [ACC_W-1:0]  acc;

  assign accept = (state == RUN) && in_valid;
  assign clr    = (state == IDLE) && start;
  // DONE is the output-register cycle, so busy drops exactly as done rises.
  assign busy   = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (accept && sample_cnt == LAST_IDX) state_nxt = DRAIN;
      DRAIN:   if (drain_cnt == 1'b0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state      <= IDLE;
      drain_cnt  <= 1'b0;
      sample_cnt <= '0;
      acc        <= '0;
      done       <= 1'b0;
      mse        <= '0;
    end else begin
      state <= state_nxt;
      done  <= (state == DONE);
      if (state == RUN)                           drain_cnt <= 1'(DRAIN_CYCLES - 1);
      else if (state == DRAIN && drain_cnt != 0)  drain_cnt <= drain_cnt - 1'b1;
      if (clr)         sample_cnt <= '0;
      else if (accept) sample_cnt <= sample_cnt + 1'b1;
      if (clr)         acc <= '0;
      else if (s2_vld) acc <= acc + ACC_W'(sq);
      if (state == DONE) mse <= acc[ACC_W-1:LOG2_N];
    end
  end

`ifdef FIR_MSE_PEAK_EN
  logic              s1_vld;
  logic [DATA_W:0]   abs_diff;
  logic [DATA_W:0]   peak;

  sq_err_stage #(.DATA_W(DATA_W)) u_sq (
    .clk      (clk),
    .rstN     (rstN),
    .clr      (clr),
    .in_vld   (accept),
    .y_ref    (y_ref),
    .y_apx    (y_apx),
    .s1_vld   (s1_vld),
    .abs_diff (abs_diff),
    .s2_vld   (s2_vld),
    .sq       (sq)
  );

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      peak     <= '0;
      err_peak <= '0;
    end else begin
      if (clr)                          peak <= '0;
      else if (s1_vld && abs_diff > peak) peak <= abs_diff;
      if (state == DONE) err_peak <= peak;
    end
  end
`else
  sq_err_stage #(.DATA_W(DATA_W)) u_sq (
    .clk    (clk),
    .rstN   (rstN),
    .clr    (clr),
    .in_vld (accept),
    .y_ref  (y_ref),
    .y_apx  (y_apx),
    .s2_vld (s2_vld),
    .sq     (sq)
  );

  assign err_peak = '0;
`endif

endmodule
